// File: rtl/regfile_wb_pkg.sv
// Shared constants and types for the register-file write-back arbiter.
package regfile_wb_pkg;

    localparam int unsigned DATA_W_DEF = 32;
    localparam int unsigned ADDR_W_DEF = 4;

    localparam int unsigned REQ_A   = 0;
    localparam int unsigned REQ_B   = 1;
    localparam int unsigned NUM_REQ = 2;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_A    = 2'd1,
        GNT_B    = 2'd2
    } gnt_e;

    function automatic int unsigned onehot_w(input int unsigned addr_w);
        return 1 << addr_w;
    endfunction

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Handshake bundle between the two write-back requesters, the arbiter and the register file port.
interface regfile_wb_arbiter_if #(
    parameter int unsigned DATA_W = regfile_wb_pkg::DATA_W_DEF,
    parameter int unsigned ADDR_W = regfile_wb_pkg::ADDR_W_DEF
);
    import regfile_wb_pkg::*;

    localparam int unsigned NREG = onehot_w(ADDR_W);

    logic              a_valid;
    logic              a_ready;
    logic [ADDR_W-1:0] a_dest;
    logic [DATA_W-1:0] a_data;
    logic              b_valid;
    logic              b_ready;
    logic [ADDR_W-1:0] b_dest;
    logic [DATA_W-1:0] b_data;
    logic              wb_en;
    logic [ADDR_W-1:0] wb_dest;
    logic [DATA_W-1:0] wb_data;
    logic [NREG-1:0]   pend_mask;

    modport slave (
        input  a_valid, a_dest, a_data, b_valid, b_dest, b_data,
        output a_ready, b_ready, wb_en, wb_dest, wb_data, pend_mask
    );

    modport master (
        output a_valid, a_dest, a_data, b_valid, b_dest, b_data,
        input  a_ready, b_ready, wb_en, wb_dest, wb_data, pend_mask
    );

endinterface

// File: rtl/wb_hold_slot.sv
// One-entry valid/ready hold slot; drained by the arbiter and refillable on the same edge.
module wb_hold_slot
    import regfile_wb_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ADDR_W-1:0] in_dest,
    input  logic [DATA_W-1:0] in_data,
    input  logic              drain,
    output logic              load,
    output logic              full,
    output logic [ADDR_W-1:0] dest,
    output logic [DATA_W-1:0] data
);

    logic              full_q, full_d;
    logic [ADDR_W-1:0] dest_q, dest_d;
    logic [DATA_W-1:0] data_q, data_d;

    always_comb begin
        in_ready = !full_q || drain;
        load     = in_valid && in_ready;
        full_d   = full_q;
        dest_d   = dest_q;
        data_d   = data_q;
        if (drain) full_d = 1'b0;
        if (load) begin
            full_d = 1'b1;
            dest_d = in_dest;
            data_d = in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            full_q <= 1'b0;
            dest_q <= '0;
            data_q <= '0;
        end else begin
            full_q <= full_d;
            dest_q <= dest_d;
            data_q <= data_d;
        end
    end

    assign full = full_q;
    assign dest = dest_q;
    assign data = data_q;

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates the pipeline WB stage (A) and the SRAM return path (B) onto the single
// register-file write port, with a starvation limit on B and same-register age ordering.
module regfile_wb_arbiter
    import regfile_wb_pkg::*;
#(
    parameter int unsigned DATA_W     = DATA_W_DEF,
    parameter int unsigned ADDR_W     = ADDR_W_DEF,
    parameter int unsigned STARVE_MAX = 3
) (
    input  logic                clk,
    input  logic                rst,
    regfile_wb_arbiter_if.slave bus
);

    localparam int unsigned NREG       = onehot_w(ADDR_W);
    localparam logic [2:0]  STARVE_LIM = 3'(STARVE_MAX);

    logic              a_full, b_full, a_load, b_load;
    logic [ADDR_W-1:0] a_dest_s, b_dest_s;
    logic [DATA_W-1:0] a_data_s, b_data_s;
    gnt_e              gnt_sel;
    logic [NUM_REQ-1:0] gnt;

    logic [2:0]        starve_q, starve_d;
    logic              b_older_q, b_older_d;
    logic              wb_en_q, wb_en_d;
    logic [ADDR_W-1:0] wb_dest_q, wb_dest_d;
    logic [DATA_W-1:0] wb_data_q, wb_data_d;
    logic [NREG-1:0]   pend;

    wb_hold_slot #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_slot_a (
        .clk(clk), .rst(rst),
        .in_valid(bus.a_valid), .in_ready(bus.a_ready),
        .in_dest(bus.a_dest), .in_data(bus.a_data),
        .drain(gnt[REQ_A]), .load(a_load),
        .full(a_full), .dest(a_dest_s), .data(a_data_s)
    );

    wb_hold_slot #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_slot_b (
        .clk(clk), .rst(rst),
        .in_valid(bus.b_valid), .in_ready(bus.b_ready),
        .in_dest(bus.b_dest), .in_data(bus.b_data),
        .drain(gnt[REQ_B]), .load(b_load),
        .full(b_full), .dest(b_dest_s), .data(b_data_s)
    );

    // Grant looks only at slot contents, never at the incoming requests.
    always_comb begin
        gnt_sel = GNT_NONE;
        if (a_full && b_full) begin
            if (a_dest_s == b_dest_s) gnt_sel = b_older_q ? GNT_B : GNT_A;
            else                      gnt_sel = (starve_q == STARVE_LIM) ? GNT_B : GNT_A;
        end else if (a_full) begin
            gnt_sel = GNT_A;
        end else if (b_full) begin
            gnt_sel = GNT_B;
        end
        gnt = '0;
        case (gnt_sel)
            GNT_A:   gnt[REQ_A] = 1'b1;
            GNT_B:   gnt[REQ_B] = 1'b1;
            default: gnt = '0;
        endcase
    end

    // b_older also covers a same-edge load of both slots, so B drains first and A's value lands last.
    always_comb begin
        b_older_d = b_older_q;
        if (a_load && b_load)  b_older_d = 1'b1;
        else if (a_load)       b_older_d = b_full && !gnt[REQ_B];
        else if (b_load)       b_older_d = !(a_full && !gnt[REQ_A]);

        starve_d = starve_q;
        if (!b_full || gnt[REQ_B])      starve_d = '0;
        else if (starve_q != STARVE_LIM) starve_d = starve_q + 3'd1;

        wb_en_d   = |gnt;
        wb_dest_d = wb_dest_q;
        wb_data_d = wb_data_q;
        if (gnt[REQ_B]) begin
            wb_dest_d = b_dest_s;
            wb_data_d = b_data_s;
        end else if (gnt[REQ_A]) begin
            wb_dest_d = a_dest_s;
            wb_data_d = a_data_s;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            starve_q  <= '0;
            b_older_q <= 1'b0;
            wb_en_q   <= 1'b0;
            wb_dest_q <= '0;
            wb_data_q <= '0;
        end else begin
            starve_q  <= starve_d;
            b_older_q <= b_older_d;
            wb_en_q   <= wb_en_d;
            wb_dest_q <= wb_dest_d;
            wb_data_q <= wb_data_d;
        end
    end

    always_comb begin
        pend = '0;
        if (a_full)  pend[a_dest_s]  = 1'b1;
        if (b_full)  pend[b_dest_s]  = 1'b1;
        if (wb_en_q) pend[wb_dest_q] = 1'b1;
    end

    assign bus.wb_en     = wb_en_q;
    assign bus.wb_dest   = wb_dest_q;
    assign bus.wb_data   = wb_data_q;
    assign bus.pend_mask = pend;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: reset, A streaming, starvation, same-register ordering,
// a short randomized drain/refill run against a write scoreboard, and mid-burst reset.
module tb_regfile_wb_arbiter;

    typedef struct packed {
        logic [3:0]  dest;
        logic [31:0] data;
    } wr_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_vec = 0;
    int   n_err = 0;
    int   n_acc = 0;
    int   n_wr  = 0;
    bit   sb_on = 1'b0;
    logic [31:0] regs [16];
    wr_t  sbq [$];

    regfile_wb_arbiter_if #(.DATA_W(32), .ADDR_W(4)) bus ();

    regfile_wb_arbiter #(.DATA_W(32), .ADDR_W(4), .STARVE_MAX(3)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one edge, sample 1 time unit later, and track writes into the register model.
    task automatic tick();
        int idx;
        @(posedge clk);
        #1;
        if (bus.wb_en === 1'b1) begin
            regs[bus.wb_dest] = bus.wb_data;
            if (sb_on) begin
                n_wr++;
                idx = -1;
                for (int i = 0; i < sbq.size(); i++)
                    if (idx < 0 && sbq[i].dest == bus.wb_dest) idx = i;
                chk("sb_write_expected", 64'(idx >= 0), 64'd1);
                if (idx >= 0) begin
                    chk("sb_write_data", 64'(bus.wb_data), 64'(sbq[idx].data));
                    sbq.delete(idx);
                end
            end
        end
    endtask

    initial begin
        logic a_acc, b_acc;
        wr_t  w;
        logic [15:0] seq;
        seq = 16'd0;
        for (int i = 0; i < 16; i++) regs[i] = '0;
        bus.a_valid = 1'b0; bus.a_dest = '0; bus.a_data = '0;
        bus.b_valid = 1'b0; bus.b_dest = '0; bus.b_data = '0;

        // Reset and idle
        tick(); tick();
        chk("rst_a_ready", 64'(bus.a_ready), 64'd1);
        chk("rst_b_ready", 64'(bus.b_ready), 64'd1);
        chk("rst_wb_en", 64'(bus.wb_en), 64'd0);
        chk("rst_wb_dest", 64'(bus.wb_dest), 64'd0);
        chk("rst_wb_data", 64'(bus.wb_data), 64'd0);
        chk("rst_pend", 64'(bus.pend_mask), 64'd0);
        rst = 1'b0;
        tick();
        chk("idle_wb_en", 64'(bus.wb_en), 64'd0);

        // A only, three back-to-back writes
        bus.a_valid = 1'b1; bus.a_dest = 4'd3; bus.a_data = 32'h11;
        chk("aonly_ready", 64'(bus.a_ready), 64'd1);
        tick();
        chk("aonly_lat_wb_en", 64'(bus.wb_en), 64'd0);
        chk("aonly_pend0", 64'(bus.pend_mask), 64'h0008);
        bus.a_dest = 4'd4; bus.a_data = 32'h22;
        tick();
        chk("aonly_w1_en", 64'(bus.wb_en), 64'd1);
        chk("aonly_w1_dest", 64'(bus.wb_dest), 64'd3);
        chk("aonly_w1_data", 64'(bus.wb_data), 64'h11);
        chk("aonly_pend1", 64'(bus.pend_mask), 64'h0018);
        bus.a_dest = 4'd5; bus.a_data = 32'h33;
        tick();
        chk("aonly_w2_en", 64'(bus.wb_en), 64'd1);
        chk("aonly_w2_dest", 64'(bus.wb_dest), 64'd4);
        chk("aonly_w2_data", 64'(bus.wb_data), 64'h22);
        bus.a_valid = 1'b0;
        tick();
        chk("aonly_w3_en", 64'(bus.wb_en), 64'd1);
        chk("aonly_w3_dest", 64'(bus.wb_dest), 64'd5);
        chk("aonly_w3_data", 64'(bus.wb_data), 64'h33);
        tick();
        chk("aonly_done_en", 64'(bus.wb_en), 64'd0);
        chk("aonly_done_pend", 64'(bus.pend_mask), 64'd0);

        // Starvation: A saturating on R0..R5, B (R7,0xBEEF) forced after three lost cycles
        bus.a_valid = 1'b1; bus.a_dest = 4'd0; bus.a_data = 32'h100;
        tick();
        bus.a_dest = 4'd1; bus.a_data = 32'h101;
        bus.b_valid = 1'b1; bus.b_dest = 4'd7; bus.b_data = 32'hBEEF;
        chk("starve_b_ready", 64'(bus.b_ready), 64'd1);
        tick();
        bus.b_valid = 1'b0;
        chk("starve_wb0_dest", 64'(bus.wb_dest), 64'd0);
        for (int i = 2; i <= 4; i++) begin
            chk("starve_a_ready", 64'(bus.a_ready), 64'd1);
            bus.a_dest = 4'(i); bus.a_data = 32'h100 + 32'(i);
            tick();
            chk("starve_wb_dest", 64'(bus.wb_dest), 64'(i - 1));
        end
        chk("starve_a_stall", 64'(bus.a_ready), 64'd0);
        chk("starve_pend", 64'(bus.pend_mask), 64'h0098);
        bus.a_dest = 4'd5; bus.a_data = 32'h105;
        tick();
        chk("starve_b_dest", 64'(bus.wb_dest), 64'd7);
        chk("starve_b_data", 64'(bus.wb_data), 64'hBEEF);
        chk("starve_a_resume", 64'(bus.a_ready), 64'd1);
        tick();
        bus.a_valid = 1'b0;
        chk("starve_r4_dest", 64'(bus.wb_dest), 64'd4);
        tick();
        chk("starve_r5_dest", 64'(bus.wb_dest), 64'd5);
        chk("starve_r5_data", 64'(bus.wb_data), 64'h105);
        tick();
        chk("starve_idle", 64'(bus.wb_en), 64'd0);

        // Same-edge A (R2,0xA) and B (R2,0xB): B first, A last
        bus.a_valid = 1'b1; bus.a_dest = 4'd2; bus.a_data = 32'hA;
        bus.b_valid = 1'b1; bus.b_dest = 4'd2; bus.b_data = 32'hB;
        tick();
        bus.a_valid = 1'b0; bus.b_valid = 1'b0;
        chk("same_pend", 64'(bus.pend_mask), 64'h0004);
        tick();
        chk("same_w1_data", 64'(bus.wb_data), 64'hB);
        tick();
        chk("same_w2_data", 64'(bus.wb_data), 64'hA);
        chk("same_w2_dest", 64'(bus.wb_dest), 64'd2);
        tick();
        chk("same_idle", 64'(bus.wb_en), 64'd0);
        chk("same_final_r2", 64'(regs[2]), 64'hA);

        // B (R9,0x1) one edge older than A (R9,0x2) while A holds R1
        bus.a_valid = 1'b1; bus.a_dest = 4'd1; bus.a_data = 32'h55;
        bus.b_valid = 1'b1; bus.b_dest = 4'd9; bus.b_data = 32'h1;
        tick();
        bus.b_valid = 1'b0;
        bus.a_dest = 4'd9; bus.a_data = 32'h2;
        chk("age_a_ready", 64'(bus.a_ready), 64'd1);
        chk("age_b_ready", 64'(bus.b_ready), 64'd0);
        tick();
        bus.a_valid = 1'b0;
        chk("age_w0_dest", 64'(bus.wb_dest), 64'd1);
        chk("age_pend0", 64'(bus.pend_mask), 64'h0202);
        tick();
        chk("age_w1_dest", 64'(bus.wb_dest), 64'd9);
        chk("age_w1_data", 64'(bus.wb_data), 64'h1);
        chk("age_pend1", 64'(bus.pend_mask), 64'h0200);
        tick();
        chk("age_w2_data", 64'(bus.wb_data), 64'h2);
        chk("age_pend2", 64'(bus.pend_mask), 64'h0200);
        tick();
        chk("age_pend3", 64'(bus.pend_mask), 64'd0);
        chk("age_final_r9", 64'(regs[9]), 64'h2);

        // Random drain/refill on both slots against the write scoreboard
        sb_on = 1'b1;
        for (int c = 0; c < 20; c++) begin
            bus.a_valid = ($urandom_range(0, 9) < 7);
            bus.a_dest  = 4'($urandom_range(0, 3));
            bus.a_data  = {16'hA000, seq};
            bus.b_valid = ($urandom_range(0, 9) < 7);
            bus.b_dest  = 4'($urandom_range(0, 3));
            bus.b_data  = {16'hB000, seq};
            seq = seq + 16'd1;
            a_acc = bus.a_valid && bus.a_ready;
            b_acc = bus.b_valid && bus.b_ready;
            tick();
            if (b_acc) begin
                w.dest = bus.b_dest; w.data = bus.b_data;
                sbq.push_back(w); n_acc++;
            end
            if (a_acc) begin
                w.dest = bus.a_dest; w.data = bus.a_data;
                sbq.push_back(w); n_acc++;
            end
        end
        bus.a_valid = 1'b0; bus.b_valid = 1'b0;
        for (int c = 0; c < 6; c++) tick();
        chk("sb_leftover", 64'(sbq.size()), 64'd0);
        chk("sb_count", 64'(n_wr), 64'(n_acc));
        sb_on = 1'b0;

        // Reset mid-burst with both slots full
        bus.a_valid = 1'b1; bus.a_dest = 4'd1; bus.a_data = 32'hDEAD;
        bus.b_valid = 1'b1; bus.b_dest = 4'd2; bus.b_data = 32'hFACE;
        tick();
        bus.a_valid = 1'b0; bus.b_valid = 1'b0;
        chk("rstmid_pend_before", 64'(bus.pend_mask), 64'h0006);
        rst = 1'b1;
        tick();
        chk("rstmid_wb_en1", 64'(bus.wb_en), 64'd0);
        chk("rstmid_pend", 64'(bus.pend_mask), 64'd0);
        rst = 1'b0;
        tick();
        chk("rstmid_wb_en2", 64'(bus.wb_en), 64'd0);
        chk("rstmid_a_ready", 64'(bus.a_ready), 64'd1);
        chk("rstmid_b_ready", 64'(bus.b_ready), 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
